// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Brief    : Shared state encodings, BCD limits and BCD helper functions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam logic [2:0] c_ST_RUN    = 3'd0;
    localparam logic [2:0] c_ST_SET_H  = 3'd1;
    localparam logic [2:0] c_ST_SET_M  = 3'd2;
    localparam logic [2:0] c_ST_SET_AH = 3'd3;
    localparam logic [2:0] c_ST_SET_AM = 3'd4;

    localparam logic [7:0] c_BCD_MAX_MIN  = 8'h59;
    localparam logic [7:0] c_BCD_MAX_HOUR = 8'h23;
    localparam logic [7:0] c_BCD_NOON     = 8'h12;

    typedef struct packed {
        logic [7:0] next;
        logic       wrap;
    } bcd_inc_t;

    typedef struct packed {
        logic [7:0] hour12;
        logic       pm;
    } hour12_t;

    function automatic bcd_inc_t bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        bcd_inc_t r;
        if (value == limit) begin
            r.next = 8'h00;
            r.wrap = 1'b1;
        end else if (value[3:0] == 4'd9) begin
            r.next = {value[7:4] + 4'd1, 4'd0};
            r.wrap = 1'b0;
        end else begin
            r.next = {value[7:4], value[3:0] + 4'd1};
            r.wrap = 1'b0;
        end
        return r;
    endfunction

    // 20 and 21 borrow across the tens digit, so a plain hex subtract is wrong there.
    function automatic hour12_t bcd_to_12h(input logic [7:0] hour);
        hour12_t r;
        r.pm = (hour >= c_BCD_NOON);
        case (hour)
            8'h00:   r.hour12 = c_BCD_NOON;
            8'h20:   r.hour12 = 8'h08;
            8'h21:   r.hour12 = 8'h09;
            default: r.hour12 = (hour > c_BCD_NOON) ? (hour - c_BCD_NOON) : hour;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// Module   : bcd_mod_counter
// Brief    : Two-digit BCD modulo counter (00..MAX) with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       inc,
    input  logic       load_zero,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] r_value;
    bcd_inc_t   w_step;

    always_comb begin
        w_step = bcd_inc(r_value, MAX);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_value <= 8'h00;
        end else if (load_zero) begin
            r_value <= 8'h00;
        end else if (inc) begin
            r_value <= w_step.next;
        end
    end

    assign value = r_value;
    assign wrap  = inc && w_step.wrap;

endmodule

`default_nettype wire

// File: rtl/bcd_timekeeper.sv
// ============================================================================
// Module   : bcd_timekeeper
// Brief    : HH:MM:SS BCD clock with prescaler, set-mode FSM, HH:MM alarm and
//            12/24-hour display formatting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_timekeeper
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int RING_SECS     = 60
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        enable,
    input  logic        mode_btn,
    input  logic        inc_btn,
    input  logic        stop_btn,
    input  logic        alarm_en,
    input  logic        hour_mode,
    input  logic        disp_sel,
    output logic [7:0]  osecond,
    output logic [7:0]  ominute,
    output logic [7:0]  ohour,
    output logic [15:0] disp_digits,
    output logic        pm,
    output logic        alarm_ring,
    output logic        sec_tick,
    output logic [2:0]  state
);

    localparam int c_PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int c_RING_W  = $clog2(RING_SECS + 1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic                 w_run;
    logic                 w_alarm_view;
    logic                 w_leave_set_m;
    logic                 w_set_h_inc;
    logic                 w_set_m_inc;
    logic                 w_set_ah_inc;
    logic                 w_set_am_inc;

    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_sec_tick;
    logic                 w_tick;

    logic                 w_sec_wrap;
    logic                 w_min_wrap;
    logic                 w_unused_hour_wrap;
    logic                 w_unused_ahour_wrap;
    logic                 w_unused_amin_wrap;
    logic [7:0]           w_alarm_hour;
    logic [7:0]           w_alarm_min;

    bcd_inc_t             w_min_step;
    bcd_inc_t             w_hour_step;
    logic                 w_trigger;
    logic                 r_ring;
    logic [c_RING_W-1:0]  r_ring_cnt;

    logic [7:0]           w_hour_src;
    hour12_t              w_h12;
    logic [7:0]           w_hour_disp;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN:    if (mode_btn) w_state_next = c_ST_SET_H;
            c_ST_SET_H:  if (mode_btn) w_state_next = c_ST_SET_M;
            c_ST_SET_M:  if (mode_btn) w_state_next = c_ST_SET_AH;
            c_ST_SET_AH: if (mode_btn) w_state_next = c_ST_SET_AM;
            c_ST_SET_AM: if (mode_btn) w_state_next = c_ST_RUN;
            default:     w_state_next = c_ST_RUN;
        endcase
    end

    // A mode press in the same cycle swallows the increment.
    always_comb begin
        w_run         = (r_state == c_ST_RUN);
        w_alarm_view  = (r_state == c_ST_SET_AH) || (r_state == c_ST_SET_AM);
        w_leave_set_m = (r_state == c_ST_SET_M) && mode_btn;
        w_set_h_inc   = (r_state == c_ST_SET_H)  && inc_btn && !mode_btn;
        w_set_m_inc   = (r_state == c_ST_SET_M)  && inc_btn && !mode_btn;
        w_set_ah_inc  = (r_state == c_ST_SET_AH) && inc_btn && !mode_btn;
        w_set_am_inc  = (r_state == c_ST_SET_AM) && inc_btn && !mode_btn;
    end

    // ---------------------------------------------------------- prescaler
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            if (!w_run) begin
                r_presc <= '0;
            end else if (enable) begin
                if (r_presc == c_PRESC_W'(TICKS_PER_SEC - 1)) begin
                    r_presc    <= '0;
                    r_sec_tick <= 1'b1;
                end else begin
                    r_presc <= r_presc + c_PRESC_W'(1);
                end
            end
        end
    end

    assign w_tick = r_sec_tick && w_run;

    // ----------------------------------------------------------- counters
    bcd_mod_counter #(.MAX(c_BCD_MAX_MIN)) u_sec (
        .clk       (clk),
        .clr_n     (clr_n),
        .inc       (w_tick),
        .load_zero (w_leave_set_m),
        .value     (osecond),
        .wrap      (w_sec_wrap)
    );

    // Minute wraps from the set FSM never carry because w_tick is low outside RUN.
    bcd_mod_counter #(.MAX(c_BCD_MAX_MIN)) u_min (
        .clk       (clk),
        .clr_n     (clr_n),
        .inc       ((w_tick && w_sec_wrap) || w_set_m_inc),
        .load_zero (1'b0),
        .value     (ominute),
        .wrap      (w_min_wrap)
    );

    bcd_mod_counter #(.MAX(c_BCD_MAX_HOUR)) u_hour (
        .clk       (clk),
        .clr_n     (clr_n),
        .inc       ((w_tick && w_min_wrap) || w_set_h_inc),
        .load_zero (1'b0),
        .value     (ohour),
        .wrap      (w_unused_hour_wrap)
    );

    bcd_mod_counter #(.MAX(c_BCD_MAX_HOUR)) u_alarm_hour (
        .clk       (clk),
        .clr_n     (clr_n),
        .inc       (w_set_ah_inc),
        .load_zero (1'b0),
        .value     (w_alarm_hour),
        .wrap      (w_unused_ahour_wrap)
    );

    bcd_mod_counter #(.MAX(c_BCD_MAX_MIN)) u_alarm_min (
        .clk       (clk),
        .clr_n     (clr_n),
        .inc       (w_set_am_inc),
        .load_zero (1'b0),
        .value     (w_alarm_min),
        .wrap      (w_unused_amin_wrap)
    );

    // -------------------------------------------------------------- alarm
    // Compare against the time this tick is about to produce, so the ring
    // rises on the same edge that shows HH:MM:00.
    always_comb begin
        w_min_step  = bcd_inc(ominute, c_BCD_MAX_MIN);
        w_hour_step = bcd_inc(ohour, c_BCD_MAX_HOUR);
        w_trigger   = w_tick && alarm_en && w_sec_wrap
                   && (w_min_step.next == w_alarm_min)
                   && ((w_min_step.wrap ? w_hour_step.next : ohour) == w_alarm_hour);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (stop_btn || !alarm_en || !w_run) begin
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
        end else if (w_trigger) begin
            r_ring     <= 1'b1;
            r_ring_cnt <= c_RING_W'(RING_SECS);
        end else if (r_ring && w_tick) begin
            if (r_ring_cnt <= c_RING_W'(1)) begin
                r_ring     <= 1'b0;
                r_ring_cnt <= '0;
            end else begin
                r_ring_cnt <= r_ring_cnt - c_RING_W'(1);
            end
        end
    end

    // ------------------------------------------------------------ display
    always_comb begin
        w_hour_src  = w_alarm_view ? w_alarm_hour : ohour;
        w_h12       = bcd_to_12h(w_hour_src);
        w_hour_disp = hour_mode ? w_h12.hour12 : w_hour_src;
        pm          = w_h12.pm;
        if (w_alarm_view) begin
            disp_digits = {w_hour_disp, w_alarm_min};
        end else if (disp_sel) begin
            disp_digits = {w_hour_disp, ominute};
        end else begin
            disp_digits = {ominute, osecond};
        end
    end

    assign alarm_ring = r_ring;
    assign sec_tick   = r_sec_tick;
    assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_bcd_timekeeper.sv
// ============================================================================
// Module   : tb_bcd_timekeeper
// Brief    : Directed self-checking bench for bcd_timekeeper (4 ticks/s, 3 s ring).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_timekeeper;

    logic        clk = 1'b0;
    logic        clr_n, enable, mode_btn, inc_btn, stop_btn, alarm_en, hour_mode, disp_sel;
    logic [7:0]  osecond, ominute, ohour;
    logic [15:0] disp_digits;
    logic        pm, alarm_ring, sec_tick;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_timekeeper #(.TICKS_PER_SEC(4), .RING_SECS(3)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .enable      (enable),
        .mode_btn    (mode_btn),
        .inc_btn     (inc_btn),
        .stop_btn    (stop_btn),
        .alarm_en    (alarm_en),
        .hour_mode   (hour_mode),
        .disp_sel    (disp_sel),
        .osecond     (osecond),
        .ominute     (ominute),
        .ohour       (ohour),
        .disp_digits (disp_digits),
        .pm          (pm),
        .alarm_ring  (alarm_ring),
        .sec_tick    (sec_tick),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    // Stimulus helpers: all assume the caller sits just after a negedge.
    task automatic do_reset;
        clr_n = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; stop_btn = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic pulse_mode;
        mode_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc_btn = 1'b1;
            @(negedge clk);
            inc_btn = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_sec(input logic [7:0] v, input int budget, output bit ok);
        int k = 0;
        while (osecond !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (osecond === v);
    endtask

    task automatic wait_ring(input logic lvl, input int budget, output bit ok);
        int k = 0;
        while (alarm_ring !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (alarm_ring === lvl);
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ohour, ominute, osecond} !== 24'h000000) begin
            n_fail++; $display("FAIL reset_time: got %h required 000000", {ohour, ominute, osecond});
        end
        n_checks++;
        if ({state, alarm_ring, sec_tick, pm} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {state, alarm_ring, sec_tick, pm});
        end
    endtask

    task automatic test_prescaler;
        bit tick_ok = 1'b1;
        clr_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sec_tick !== ((k % 4) == 0)) tick_ok = 1'b0;
        end
        n_checks++;
        if (!tick_ok) begin
            n_fail++; $display("FAIL tick_period: got irregular sec_tick required every 4th cycle");
        end
        n_checks++;
        if (osecond !== 8'h02) begin
            n_fail++; $display("FAIL sec_count: got %h required 02", osecond);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (osecond !== 8'h03) begin
            n_fail++; $display("FAIL sec_count3: got %h required 03", osecond);
        end
        clr_n = 1'b0;
        #1;
        n_checks++;
        if ({osecond, disp_digits, state} !== 27'd0) begin
            n_fail++; $display("FAIL async_clear: got %h/%h/%0d required 00/0000/0", osecond, disp_digits, state);
        end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_rollover;
        bit bad = 1'b0;
        bit ok;
        int k = 0;
        do_reset();
        enable = 1'b0;
        pulse_mode();
        pulse_inc(23);
        n_checks++;
        if (ohour !== 8'h23) begin
            n_fail++; $display("FAIL set_hour23: got %h required 23", ohour);
        end
        pulse_mode();
        pulse_inc(59);
        n_checks++;
        if ({ohour, ominute} !== 16'h2359) begin
            n_fail++; $display("FAIL set_2359: got %h required 2359", {ohour, ominute});
        end
        pulse_mode(); pulse_mode(); pulse_mode();
        enable = 1'b1;
        while (osecond !== 8'h59 && k < 300) begin
            @(negedge clk);
            k++;
            if (osecond[3:0] > 4'd9 || osecond[7:4] > 4'd5) bad = 1'b1;
        end
        n_checks++;
        if (bad || osecond !== 8'h59) begin
            n_fail++; $display("FAIL sec_run: got %h bad=%0d required 59 with valid BCD", osecond, bad);
        end
        k = 0;
        while (sec_tick !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        ok = (sec_tick === 1'b1);
        n_checks++;
        if (!ok || {ohour, ominute, osecond} !== 24'h235959) begin
            n_fail++; $display("FAIL pre_midnight: got %h tick=%0d required 235959", {ohour, ominute, osecond}, sec_tick);
        end
        @(negedge clk);
        n_checks++;
        if ({ohour, ominute, osecond} !== 24'h000000) begin
            n_fail++; $display("FAIL midnight: got %h required 000000", {ohour, ominute, osecond});
        end
    endtask

    task automatic test_display;
        do_reset();
        enable = 1'b0; hour_mode = 1'b1; disp_sel = 1'b1;
        #1;
        n_checks++;
        if ({disp_digits, pm} !== {16'h1200, 1'b0}) begin
            n_fail++; $display("FAIL disp_h00: got %h pm=%0d required 1200 pm=0", disp_digits, pm);
        end
        disp_sel = 1'b0;
        #1;
        n_checks++;
        if (disp_digits !== 16'h0000) begin
            n_fail++; $display("FAIL disp_mmss: got %h required 0000", disp_digits);
        end
        disp_sel = 1'b1;
        pulse_mode();
        pulse_inc(12);
        n_checks++;
        if ({disp_digits, pm} !== {16'h1200, 1'b1}) begin
            n_fail++; $display("FAIL disp_h12: got %h pm=%0d required 1200 pm=1", disp_digits, pm);
        end
        pulse_inc(1);
        n_checks++;
        if ({disp_digits, pm} !== {16'h0100, 1'b1}) begin
            n_fail++; $display("FAIL disp_h13_12h: got %h pm=%0d required 0100 pm=1", disp_digits, pm);
        end
        hour_mode = 1'b0;
        #1;
        n_checks++;
        if ({disp_digits, pm} !== {16'h1300, 1'b1}) begin
            n_fail++; $display("FAIL disp_h13_24h: got %h pm=%0d required 1300 pm=1", disp_digits, pm);
        end
        pulse_mode();
        pulse_inc(7);
        pulse_inc(13);
        hour_mode = 1'b1;
        #1;
        n_checks++;
        if (disp_digits !== 16'h0120) begin
            n_fail++; $display("FAIL disp_h13m20: got %h required 0120", disp_digits);
        end
        pulse_mode();
        disp_sel = 1'b0;
        #1;
        n_checks++;
        if ({disp_digits, pm} !== {16'h1200, 1'b0}) begin
            n_fail++; $display("FAIL disp_alarm_view: got %h pm=%0d required 1200 pm=0", disp_digits, pm);
        end
    endtask

    task automatic test_set_mode;
        bit ok;
        do_reset();
        enable = 1'b1; hour_mode = 1'b0;
        wait_sec(8'h02, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL sec_reach02: got %h required 02", osecond);
        end
        pulse_mode();
        pulse_inc(25);
        n_checks++;
        if ({state, ohour, osecond} !== {3'd1, 8'h01, 8'h02}) begin
            n_fail++; $display("FAIL set_h25: got st=%0d %h/%h required st=1 01/02", state, ohour, osecond);
        end
        pulse_mode();
        pulse_inc(60);
        n_checks++;
        if ({state, ohour, ominute, osecond} !== {3'd2, 24'h010002}) begin
            n_fail++; $display("FAIL set_m_wrap: got st=%0d %h%h%h required st=2 010002", state, ohour, ominute, osecond);
        end
        pulse_mode();
        n_checks++;
        if ({state, osecond} !== {3'd3, 8'h00}) begin
            n_fail++; $display("FAIL leave_set_m: got st=%0d sec=%h required st=3 sec=00", state, osecond);
        end
        mode_btn = 1'b1; inc_btn = 1'b1;
        @(negedge clk);
        mode_btn = 1'b0; inc_btn = 1'b0;
        n_checks++;
        if ({state, disp_digits} !== {3'd4, 16'h0000}) begin
            n_fail++; $display("FAIL mode_inc_same: got st=%0d disp=%h required st=4 disp=0000", state, disp_digits);
        end
        pulse_mode();
        n_checks++;
        if (state !== 3'd0) begin
            n_fail++; $display("FAIL back_to_run: got %0d required 0", state);
        end
    endtask

    task automatic test_alarm;
        bit ok;
        do_reset();
        enable = 1'b0; alarm_en = 1'b0; hour_mode = 1'b0;
        pulse_mode(); pulse_inc(7);
        pulse_mode(); pulse_inc(29);
        pulse_mode(); pulse_inc(7);
        pulse_mode(); pulse_inc(30);
        pulse_mode();
        alarm_en = 1'b1; enable = 1'b1;
        wait_sec(8'h59, 300, ok);
        wait_ring(1'b1, 10, ok);
        n_checks++;
        if (!ok || {ohour, ominute, osecond} !== 24'h073000) begin
            n_fail++; $display("FAIL ring_rise: got ring=%0d at %h required ring=1 at 073000", alarm_ring, {ohour, ominute, osecond});
        end
        wait_ring(1'b0, 30, ok);
        n_checks++;
        if (!ok || osecond !== 8'h03) begin
            n_fail++; $display("FAIL ring_timeout: got ring=%0d sec=%h required ring=0 sec=03", alarm_ring, osecond);
        end
        // back to 07:29:00 and ring again, then stop it
        pulse_mode(); pulse_mode(); pulse_inc(59);
        pulse_mode(); pulse_mode(); pulse_mode();
        wait_sec(8'h59, 300, ok);
        wait_ring(1'b1, 10, ok);
        wait_sec(8'h01, 10, ok);
        n_checks++;
        if (!ok || alarm_ring !== 1'b1) begin
            n_fail++; $display("FAIL ring_hold: got ring=%0d sec=%h required ring=1 sec=01", alarm_ring, osecond);
        end
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
        n_checks++;
        if (alarm_ring !== 1'b0) begin
            n_fail++; $display("FAIL ring_stop: got %0d required 0", alarm_ring);
        end
        // time equal to alarm while in SET_M must not ring
        pulse_mode(); pulse_mode(); pulse_inc(60);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({alarm_ring, ohour, ominute} !== {1'b0, 16'h0730}) begin
            n_fail++; $display("FAIL set_equal_no_ring: got ring=%0d %h required ring=0 0730", alarm_ring, {ohour, ominute});
        end
        pulse_inc(59);
        pulse_mode(); pulse_mode(); pulse_mode();
        wait_sec(8'h59, 300, ok);
        wait_ring(1'b1, 10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL ring_rise2: got %0d required 1", alarm_ring);
        end
        alarm_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (alarm_ring !== 1'b0) begin
            n_fail++; $display("FAIL ring_disarm: got %0d required 0", alarm_ring);
        end
    endtask

    initial begin
        clr_n = 1'b0; enable = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; stop_btn = 1'b0;
        alarm_en = 1'b0; hour_mode = 1'b0; disp_sel = 1'b0;
        test_reset();
        test_prescaler();
        test_rollover();
        test_display();
        test_set_mode();
        test_alarm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
Fully synchronous HH:MM:SS BCD timekeeper with an on-chip seconds prescaler, a set-mode FSM, an HH:MM alarm, and 12/24-hour display formatting. All carries are in-clock-domain enables; there are no ripple clocks. It drives four BCD display digits to the existing 7-segment decoders and exposes raw time for debug.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per second (minimum 2).
RING_SECS, 60, seconds the alarm output stays asserted if not stopped (minimum 1).

Ports:
clk  in  1  system clock; all state changes on rising edge.
clr_n  in  1  reset, asynchronous, active-low.
enable  in  1  1 = time advances in RUN; 0 = prescaler and time frozen.
mode_btn  in  1  single-cycle pulse; advances the set FSM.
inc_btn  in  1  single-cycle pulse; increments the field selected by the FSM.
stop_btn  in  1  single-cycle pulse; silences a ringing alarm.
alarm_en  in  1  1 = alarm armed.
hour_mode  in  1  1 = 12-hour display, 0 = 24-hour display.
disp_sel  in  1  1 = show HH:MM, 0 = show MM:SS.
osecond  out  8  BCD seconds 00..59.
ominute  out  8  BCD minutes 00..59.
ohour  out  8  BCD hours 00..23, always 24-hour format.
disp_digits  out  16  four BCD digits {d3,d2,d1,d0}, d3 most significant.
pm  out  1  1 when the displayed hour source is 12..23.
alarm_ring  out  1  alarm active.
sec_tick  out  1  one-cycle pulse per elapsed second.
state  out  3  FSM state encoding.

Behaviour:
- Reset (clr_n low, takes effect immediately): time 00:00:00, alarm 00:00, prescaler 0, state RUN, alarm_ring 0, ring counter 0, sec_tick 0.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only when state==RUN and enable==1.
  - sec_tick is registered and goes high for one cycle in the cycle after terminal count.
  - Outside RUN the prescaler is held at 0.
- Time update on sec_tick:
  - Seconds +1; 59 wraps to 00 and carries into minutes in the same cycle.
  - Minutes 59 wraps to 00 and carries into hours; hours 23 wraps to 00.
  - 23:59:59 becomes 00:00:00 in a single cycle.
  - BCD digits never hold A..F.
- FSM states: RUN(0), SET_H(1), SET_M(2), SET_AH(3), SET_AM(4).
  - mode_btn moves RUN→SET_H→SET_M→SET_AH→SET_AM→RUN.
  - Leaving SET_M clears seconds to 00 and the prescaler to 0.
  - Encodings 5..7 are illegal and return to RUN on the next cycle.
- inc_btn per state:
  - SET_H: hour +1, 23→00.
  - SET_M: minute +1, 59→00, no carry into hour.
  - SET_AH / SET_AM: same rules applied to the alarm registers.
  - RUN: ignored.
- mode_btn and inc_btn in the same cycle: the mode transition happens and inc is dropped.
- Alarm trigger:
  - Fires when, in RUN with alarm_en=1, a sec_tick update produces time == alarm_hh:alarm_mm:00.
  - alarm_ring rises in the same edge as that time update.
  - Ring counter loads RING_SECS, decrements on each later sec_tick, and ring clears when it reaches 0.
- Alarm clear:
  - Ring clears on the next edge after stop_btn, alarm_en=0, or leaving RUN; clear has priority over trigger.
  - A re-trigger while ringing reloads the counter.
  - Setting time equal to the alarm in SET states never triggers.
- Display (combinational from registers):
  - 12h conversion: 00→12; 01..11 unchanged; 12→12; 13..23→hour-12.
  - pm = (source hour ≥ 12), independent of hour_mode; 24h mode passes the hour through.
  - disp_digits = disp_sel ? {hour_disp, ominute} : {ominute, osecond}.
  - In SET_AH / SET_AM the display shows {alarm_hour_disp, alarm_min} regardless of disp_sel, and pm follows the alarm hour.

Decomposition:
- Shared package/header clock_pkg:
  - State encodings.
  - BCD limit constants (8'h59, 8'h23, 8'h12).
  - Function bcd_to_12h(hour) returning {hour12, pm}.
  - Function bcd_inc(value, limit) returning {next, wrap}.
- One sub-module bcd_mod_counter: 2-digit BCD, parameter MAX (59 or 23), inputs inc/load_zero, outputs value and wrap.
  - Instantiated for sec, min, hour, alarm_min, alarm_hour.

Test Plan:
- TICKS_PER_SEC=4, enable=1 from reset → sec_tick every 4 cycles; osecond 8'h01 after the first tick; clr_n low mid-count → all outputs 0 immediately, state 0.
- Set 23:59:59, one sec_tick → ohour/ominute/osecond = 00/00/00 on the same edge, no intermediate 24:00 or 8'h5A values.
- hour_mode=1: hour 00 → d3d2=12, pm=0; hour 12 → 12, pm=1; hour 13 → 01, pm=1; hour_mode=0, hour 13 → 13, pm=1.
- mode_btn once, 25 inc_btn → ohour 8'h01; mode_btn, minute 59 + inc → ominute 00 with ohour unchanged; mode_btn → osecond 00; mode_btn and inc_btn in the same cycle → state advances, no increment.
- Alarm 07:30, RING_SECS=3, time 07:29:59, alarm_en=1 → alarm_ring=1 at 07:30:00, 0 at 07:30:03; repeat, stop_btn at 07:30:01 → ring 0 next cycle.
- Alarm set while in SET_M with time equal to the alarm → no ring; alarm_en=0 during ring → ring clears next edge.
